// File: rtl/i2s_tx.sv
// i2s_tx: I2S master transmitter; divides clk into BCLK/LRCLK and shifts stereo
// samples out MSB-first, one BCLK after the LRCLK edge, from a one-sample buffer.
module i2s_tx #(
   parameter int DATA_W   = 16,
   parameter int HALF_DIV = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic [DATA_W-1:0] in_left,
   input  logic [DATA_W-1:0] in_right,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              i2s_bclk,
   output logic              i2s_lrclk,
   output logic              i2s_sdata,
   output logic              frame_start,
   output logic              underrun
);
   localparam int DW = HALF_DIV > 1 ? $clog2(HALF_DIV) : 1;
   localparam int SW = $clog2(2 * DATA_W);
   localparam int FW = 2 * DATA_W;

   typedef enum logic {IDLE, RUN} state_t;

   state_t          r_state, w_next;
   logic [DW-1:0]   r_div;
   logic [SW-1:0]   r_slot;
   logic [SW-1:0]   w_nslot;
   logic [FW-1:0]   r_sh, r_buf;
   logic            r_full, r_bclk, r_lrclk, r_sdata, r_fs, r_ur;
   logic            w_wrap, w_load, w_shift, w_acc;

   assign w_acc       = in_valid & ~r_full;
   assign w_nslot     = r_slot + SW'(1);
   assign in_ready    = ~r_full;
   assign i2s_bclk    = r_bclk;
   assign i2s_lrclk   = r_lrclk;
   assign i2s_sdata   = r_sdata;
   assign frame_start = r_fs;
   assign underrun    = r_ur;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   // A load happens on entry to RUN and on the falling BCLK that ends the last slot.
   always_comb begin
      w_next  = IDLE;
      w_wrap  = 1'b0;
      w_load  = 1'b0;
      w_shift = 1'b0;
      if (enable) begin
         w_next  = RUN;
         w_wrap  = (r_state == RUN) && (r_div == DW'(HALF_DIV - 1));
         w_load  = (r_state == IDLE) || (w_wrap && r_bclk && r_slot == SW'(FW - 1));
         w_shift = w_wrap && r_bclk && !w_load;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_div   <= '0;
         r_slot  <= '0;
         r_sh    <= '0;
         r_buf   <= '0;
         r_full  <= 1'b0;
         r_bclk  <= 1'b0;
         r_lrclk <= 1'b0;
         r_sdata <= 1'b0;
         r_fs    <= 1'b0;
         r_ur    <= 1'b0;
      end else begin
         r_full <= w_acc | (r_full & ~w_load);
         if (w_acc) r_buf <= {in_left, in_right};
         r_fs <= w_load;
         r_ur <= w_load & ~r_full;
         if (!enable) begin
            r_div   <= '0;
            r_slot  <= '0;
            r_sh    <= '0;
            r_bclk  <= 1'b0;
            r_lrclk <= 1'b0;
            r_sdata <= 1'b0;
         end else if (w_load) begin
            r_div   <= '0;
            r_slot  <= '0;
            r_bclk  <= 1'b0;
            r_lrclk <= 1'b0;
            r_sdata <= r_full & r_buf[FW-1];
            r_sh    <= r_full ? {r_buf[FW-2:0], 1'b0} : '0;
         end else begin
            r_div <= w_wrap ? '0 : r_div + DW'(1);
            if (w_wrap) r_bclk <= ~r_bclk;
            if (w_shift) begin
               r_slot  <= w_nslot;
               r_sdata <= r_sh[FW-1];
               r_sh    <= {r_sh[FW-2:0], 1'b0};
               r_lrclk <= (w_nslot >= SW'(DATA_W - 1)) && (w_nslot <= SW'(FW - 2));
            end
         end
      end
   end
endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: directed bench for i2s_tx at DATA_W=16, HALF_DIV=4; outputs are
// sampled on the falling clk edge, one frame = 256 clks.
module tb_i2s_tx;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic [15:0] in_left = '0;
   logic [15:0] in_right = '0;
   logic        in_valid = 1'b0;
   logic        in_ready, i2s_bclk, i2s_lrclk, i2s_sdata, frame_start, underrun;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] q[$];
   int          qi = 0;
   logic        rdy_prev = 1'b1;
   logic [31:0] bits, lr;
   int          nr, extra, rise1, rise2;
   logic        rdy0, rdy1;

   i2s_tx #(.DATA_W(16), .HALF_DIV(4)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable),
      .in_left(in_left), .in_right(in_right), .in_valid(in_valid),
      .in_ready(in_ready), .i2s_bclk(i2s_bclk), .i2s_lrclk(i2s_lrclk),
      .i2s_sdata(i2s_sdata), .frame_start(frame_start), .underrun(underrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Source model: presents q[qi] while any remain; advances after an accepting edge.
   task automatic drive;
      in_valid = (qi < q.size());
      if (in_valid) {in_left, in_right} = q[qi];
      rdy_prev = in_ready;
   endtask

   task automatic tick;
      @(negedge clk);
      if (in_valid && rdy_prev) qi++;
      drive();
   endtask

   // Called at cycle 0 of a frame; returns at cycle 0 of the next one.
   task automatic frame(input string tag, input logic [31:0] exp, input logic exp_ur);
      logic pb;
      chk({tag, ".fs"}, 32'(frame_start), 32'd1);
      chk({tag, ".ur"}, 32'(underrun), 32'(exp_ur));
      rdy0 = in_ready;
      pb = i2s_bclk;
      bits = '0; lr = '0; nr = 0; extra = 0; rise1 = -1; rise2 = -1;
      for (int c = 1; c < 256; c++) begin
         tick();
         if (c == 1) rdy1 = in_ready;
         if (frame_start || underrun) extra++;
         if (i2s_bclk && !pb) begin
            bits = {bits[30:0], i2s_sdata};
            lr   = {lr[30:0], i2s_lrclk};
            if (nr == 0) rise1 = c;
            if (nr == 1) rise2 = c;
            nr++;
         end
         pb = i2s_bclk;
      end
      chk({tag, ".data"}, bits, exp);
      chk({tag, ".lr"}, lr, 32'h0001_FFFE);
      chk({tag, ".nbits"}, 32'(nr), 32'd32);
      chk({tag, ".pulses"}, 32'(extra), 32'd0);
      chk({tag, ".rise1"}, 32'(rise1), 32'd4);
      chk({tag, ".rise2"}, 32'(rise2), 32'd12);
      tick();
   endtask

   initial begin
      enable = 1'b1;
      repeat (4) @(negedge clk);
      chk("rst.bclk", 32'(i2s_bclk), 0);
      chk("rst.lrclk", 32'(i2s_lrclk), 0);
      chk("rst.sdata", 32'(i2s_sdata), 0);
      chk("rst.fs", 32'(frame_start), 0);
      chk("rst.ur", 32'(underrun), 0);
      chk("rst.ready", 32'(in_ready), 1);
      enable = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) tick();
      chk("idle.bclk", 32'(i2s_bclk), 0);
      chk("idle.fs", 32'(frame_start), 0);
      chk("idle.ready", 32'(in_ready), 1);

      q.push_back(32'hA5C3_8001);
      drive();
      tick();
      chk("push.ready", 32'(in_ready), 0);
      enable = 1'b1;
      tick();
      chk("fr1.ready", 32'(in_ready), 1);
      frame("fr1", 32'hA5C3_8001, 1'b0);
      frame("fr2", 32'h0, 1'b1);

      q.push_back(32'h7FFF_8000);
      q.push_back(32'h0F0F_F0F0);
      q.push_back(32'hDEAD_BEEF);
      drive();
      frame("fr3", 32'h0, 1'b1);
      chk("fr3.rdy0", 32'(rdy0), 1);
      chk("fr3.rdy1", 32'(rdy1), 0);
      frame("fr4", 32'h7FFF_8000, 1'b0);
      chk("fr4.rdy0", 32'(rdy0), 1);
      chk("fr4.rdy1", 32'(rdy1), 0);
      frame("fr5", 32'h0F0F_F0F0, 1'b0);
      chk("fr5.rdy0", 32'(rdy0), 1);
      chk("fr5.rdy1", 32'(rdy1), 0);
      frame("fr6", 32'hDEAD_BEEF, 1'b0);
      chk("fr6.rdy1", 32'(rdy1), 1);
      q.push_back(32'h1234_FFFF);
      drive();
      frame("fr7", 32'h0, 1'b1);

      chk("fr8.fs", 32'(frame_start), 1);
      chk("fr8.ur", 32'(underrun), 0);
      q.push_back(32'hCAFE_0123);
      drive();
      repeat (164) tick();
      chk("s20.bclk", 32'(i2s_bclk), 1);
      chk("s20.lrclk", 32'(i2s_lrclk), 1);
      chk("s20.sdata", 32'(i2s_sdata), 1);
      enable = 1'b0;
      tick();
      chk("drop.bclk", 32'(i2s_bclk), 0);
      chk("drop.lrclk", 32'(i2s_lrclk), 0);
      chk("drop.sdata", 32'(i2s_sdata), 0);
      chk("drop.ready", 32'(in_ready), 0);
      repeat (3) tick();
      chk("drop.idle", 32'(i2s_bclk), 0);
      q.push_back(32'hFFFF_0000);
      drive();
      enable = 1'b1;
      tick();
      frame("reen", 32'hCAFE_0123, 1'b0);

      chk("fr10.fs", 32'(frame_start), 1);
      chk("fr10.ur", 32'(underrun), 0);
      q.push_back(32'h5555_AAAA);
      drive();
      repeat (76) tick();
      chk("s9.bclk", 32'(i2s_bclk), 1);
      chk("s9.sdata", 32'(i2s_sdata), 1);
      chk("s9.lrclk", 32'(i2s_lrclk), 0);
      chk("s9.ready", 32'(in_ready), 0);
      #2 rst_n = 1'b0;
      #1;
      chk("arst.bclk", 32'(i2s_bclk), 0);
      chk("arst.sdata", 32'(i2s_sdata), 0);
      chk("arst.ready", 32'(in_ready), 1);
      enable = 1'b0;
      qi = q.size();
      drive();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("post.ready", 32'(in_ready), 1);
      chk("post.bclk", 32'(i2s_bclk), 0);
      enable = 1'b1;
      tick();
      chk("post.fs", 32'(frame_start), 1);
      chk("post.ur", 32'(underrun), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
